// File: rtl/mant_normalizer.sv
// -----------------------------------------------------------------------------
// mant_normalizer
//
// Two-stage pipelined mantissa normalizer placed after the add/multiply
// datapath. Stage 1 counts the leading zeros of the raw mantissa. Stage 2
// picks the left-shift amount, adjusts the biased exponent and clamps the
// result at the subnormal boundary when the exponent cannot absorb the full
// shift.
//
// Each stage has its own valid flag. A stage accepts new data when it is
// empty or emptying on the same edge, which gives one word per cycle at full
// throughput and lets either side stall.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset, flushes both stages
//   in_valid   input word valid
//   in_ready   stage 1 can accept (combinational from out_ready/valid flags)
//   in_mant    unnormalized mantissa            [MANT_W]
//   in_exp     biased exponent (0 = subnormal)   [EXP_W]
//   in_tag     sideband tag, carried unmodified  [TAG_W]
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   out_mant   normalized (or clamped) mantissa  [MANT_W]
//   out_exp    adjusted exponent                 [EXP_W]
//   out_shift  applied left-shift amount         [CNT_W]
//   out_zero   input mantissa was all zero
//   out_subn   result clamped to subnormal
//   out_tag    tag of the result                 [TAG_W]
// -----------------------------------------------------------------------------
module mant_normalizer #(
    parameter int MANT_W = 48,
    parameter int EXP_W  = 10,
    parameter int TAG_W  = 4,
    parameter int CNT_W  = $clog2(MANT_W + 1)
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MANT_W-1:0] in_mant,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic [TAG_W-1:0]  in_tag,

    output logic              out_valid,
    input  logic              out_ready,
    output logic [MANT_W-1:0] out_mant,
    output logic [EXP_W-1:0]  out_exp,
    output logic [CNT_W-1:0]  out_shift,
    output logic              out_zero,
    output logic              out_subn,
    output logic [TAG_W-1:0]  out_tag
);

    // -------------------------------------------------------------------------
    // Leading-zero counter.
    // The mantissa is split into 8-bit chunks counted in parallel; the first
    // non-zero chunk from the MSB side selects the result. This keeps the
    // priority chain short compared with one flat 48-bit scan.
    // -------------------------------------------------------------------------
    localparam int CHUNK_W = 8;
    localparam int CLZ_W   = $clog2(CHUNK_W + 1);
    localparam int N_CHUNK = (MANT_W + CHUNK_W - 1) / CHUNK_W;
    localparam int PAD_W   = N_CHUNK * CHUNK_W;

    logic [PAD_W-1:0]   mant_pad;
    logic [N_CHUNK-1:0] chunk_nz;
    logic [CLZ_W-1:0]   chunk_lz [N_CHUNK];
    logic [CNT_W-1:0]   lz_next;

    // Padding goes on the LSB side so leading-zero counts are unaffected for
    // any non-zero mantissa; the all-zero case is handled by the default.
    generate
        if (PAD_W == MANT_W) begin : g_nopad
            assign mant_pad = in_mant;
        end else begin : g_pad
            assign mant_pad = {in_mant, {(PAD_W - MANT_W){1'b0}}};
        end
    endgenerate

    // Chunk 0 is the most significant chunk.
    generate
        for (genvar gi = 0; gi < N_CHUNK; gi++) begin : g_chunk
            logic [CHUNK_W-1:0] bits;
            logic [CLZ_W-1:0]   lz_c;

            assign bits = mant_pad[PAD_W-1-gi*CHUNK_W -: CHUNK_W];

            // Scan upward; the highest set bit is written last and wins.
            always_comb begin
                lz_c = CLZ_W'(CHUNK_W);
                for (int b = 0; b < CHUNK_W; b++) begin
                    if (bits[b]) begin
                        lz_c = CLZ_W'(CHUNK_W - 1 - b);
                    end
                end
            end

            assign chunk_nz[gi] = |bits;
            assign chunk_lz[gi] = lz_c;
        end
    endgenerate

    // Walk chunks from LSB side to MSB side so the first non-zero chunk from
    // the top is the final assignment.
    always_comb begin
        lz_next = CNT_W'(MANT_W);
        for (int c = N_CHUNK - 1; c >= 0; c--) begin
            if (chunk_nz[c]) begin
                lz_next = CNT_W'(c * CHUNK_W) + CNT_W'(chunk_lz[c]);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Pipeline handshake
    // -------------------------------------------------------------------------
    logic s1_valid_reg;
    logic s2_valid_reg;
    logic s1_ready;
    logic s2_ready;

    assign s2_ready = ~s2_valid_reg | out_ready;
    assign s1_ready = ~s1_valid_reg | s2_ready;
    assign in_ready = s1_ready;

    // -------------------------------------------------------------------------
    // Stage 1 registers: raw word plus its leading-zero count
    // -------------------------------------------------------------------------
    logic [MANT_W-1:0] s1_mant_reg;
    logic [EXP_W-1:0]  s1_exp_reg;
    logic [TAG_W-1:0]  s1_tag_reg;
    logic [CNT_W-1:0]  s1_lz_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_mant_reg  <= '0;
            s1_exp_reg   <= '0;
            s1_tag_reg   <= '0;
            s1_lz_reg    <= '0;
        end else if (s1_ready) begin
            s1_valid_reg <= in_valid;
            if (in_valid) begin
                s1_mant_reg <= in_mant;
                s1_exp_reg  <= in_exp;
                s1_tag_reg  <= in_tag;
                s1_lz_reg   <= lz_next;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stage 2 decision logic
    // Exponent math is done one bit wider than EXP_W; the subtraction is only
    // taken when exp > lz, so the result never wraps.
    // -------------------------------------------------------------------------
    logic [EXP_W:0]    exp_ext;
    logic [EXP_W:0]    lz_ext;
    logic [EXP_W:0]    exp_minus_lz;
    logic [EXP_W:0]    exp_minus_one;
    logic              mant_is_zero;

    logic [MANT_W-1:0] s2_mant_next;
    logic [EXP_W-1:0]  s2_exp_next;
    logic [CNT_W-1:0]  s2_shift_next;
    logic              s2_zero_next;
    logic              s2_subn_next;

    assign exp_ext       = {1'b0, s1_exp_reg};
    assign lz_ext        = {{(EXP_W + 1 - CNT_W){1'b0}}, s1_lz_reg};
    assign exp_minus_lz  = exp_ext - lz_ext;
    assign exp_minus_one = exp_ext - {{EXP_W{1'b0}}, 1'b1};
    assign mant_is_zero  = (s1_mant_reg == '0);

    always_comb begin
        s2_shift_next = '0;
        s2_exp_next   = '0;
        s2_zero_next  = 1'b0;
        s2_subn_next  = 1'b0;

        if (mant_is_zero) begin
            s2_zero_next = 1'b1;
        end else if (exp_ext > lz_ext) begin
            // Full normalization fits in the exponent range.
            s2_shift_next = s1_lz_reg;
            s2_exp_next   = exp_minus_lz[EXP_W-1:0];
        end else if (s1_exp_reg != '0) begin
            // Shift only as far as exponent 1 allows, then encode as subnormal.
            // exp <= lz <= MANT_W here, so exp-1 fits the count width.
            s2_shift_next = exp_minus_one[CNT_W-1:0];
            s2_subn_next  = 1'b1;
        end else begin
            // Already subnormal: pass the mantissa through untouched.
            s2_subn_next  = 1'b1;
        end

        // Shifted-out bits are leading zeros, so nothing significant is lost.
        s2_mant_next = s1_mant_reg << s2_shift_next;
    end

    // -------------------------------------------------------------------------
    // Stage 2 registers (drive the outputs directly)
    // -------------------------------------------------------------------------
    logic [MANT_W-1:0] s2_mant_reg;
    logic [EXP_W-1:0]  s2_exp_reg;
    logic [CNT_W-1:0]  s2_shift_reg;
    logic              s2_zero_reg;
    logic              s2_subn_reg;
    logic [TAG_W-1:0]  s2_tag_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_reg <= 1'b0;
            s2_mant_reg  <= '0;
            s2_exp_reg   <= '0;
            s2_shift_reg <= '0;
            s2_zero_reg  <= 1'b0;
            s2_subn_reg  <= 1'b0;
            s2_tag_reg   <= '0;
        end else if (s2_ready) begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                s2_mant_reg  <= s2_mant_next;
                s2_exp_reg   <= s2_exp_next;
                s2_shift_reg <= s2_shift_next;
                s2_zero_reg  <= s2_zero_next;
                s2_subn_reg  <= s2_subn_next;
                s2_tag_reg   <= s1_tag_reg;
            end
        end
    end

    assign out_valid = s2_valid_reg;
    assign out_mant  = s2_mant_reg;
    assign out_exp   = s2_exp_reg;
    assign out_shift = s2_shift_reg;
    assign out_zero  = s2_zero_reg;
    assign out_subn  = s2_subn_reg;
    assign out_tag   = s2_tag_reg;

endmodule

// File: doc/mant_normalizer.md
Name: mant_normalizer

Overview:
- Two-stage pipelined normalizer for 48-bit floating-point mantissas, at the back end of the datapath after add/multiply.
- Consumes a raw mantissa and biased exponent, counts leading zeros, left-shifts the mantissa so bit 47 is set, and decrements the exponent to match.
- Clamps at the subnormal boundary.
- Stall-capable valid/ready on both sides.

Parameters:
- MANT_W, 48, mantissa width; the count width is ceil(log2(MANT_W+1)) = 6.
- EXP_W, 10, unsigned biased exponent width; exponent 0 encodes subnormal/zero.
- TAG_W, 4, sideband tag carried alongside the data, unmodified.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept the input word.
- in_mant  in  MANT_W  unnormalized mantissa.
- in_exp  in  EXP_W  biased exponent of in_mant.
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_mant  out  MANT_W  normalized mantissa.
- out_exp  out  EXP_W  adjusted exponent.
- out_shift  out  6  applied left-shift amount.
- out_zero  out  1  input mantissa was all zero.
- out_subn  out  1  result clamped to subnormal (out_exp = 0, mantissa not MSB-aligned).
- out_tag  out  TAG_W  tag of the result.

Behaviour:

Reset:
- Asynchronous assert; synchronous deassert is handled upstream.
- All valid flags cleared: out_valid = 0.
- out_mant, out_exp, out_shift, out_zero, out_subn and out_tag all reset to 0.
- in_ready = 1 from the first cycle after reset.

Handshake:
- Transfer occurs when valid & ready are both high on a clock edge.
- Stage k accepts new data when it is empty or emptying that cycle: s_k_ready = ~s_k_valid | s_(k+1)_ready.
- out_ready feeds stage 2; in_ready = stage-1 ready. in_ready is combinational from out_ready and the valid flags only, never from data.
- Full throughput: one word per cycle when out_ready is held high.
- Latency is exactly 2 cycles from input transfer to out_valid.
- A stalled stage holds all of its registers unchanged.
- out_* must not change while out_valid & ~out_ready.
- in_* are ignored when in_valid = 0.

Stage 1 (registered on input transfer):
- Computes lz = number of leading zeros of in_mant, 0..48 (48 when in_mant == 0).
- Registers lz together with in_mant, in_exp and in_tag.

Stage 2 (registered on stage-1 transfer); decision rules:
- mant == 0: shift = 0, out_mant = 0, out_exp = 0, out_zero = 1, out_subn = 0.
- exp > lz: shift = lz, out_exp = exp - lz, out_subn = 0. Bit 47 of out_mant is set.
- exp <= lz, exp != 0: shift = exp - 1, out_exp = 0, out_subn = 1.
- exp == 0: shift = 0, out_exp = 0, out_subn = 1. The mantissa passes through unchanged.
- In all cases out_mant = mant << shift with zero fill. Bits shifted out are zero by construction.
- out_shift = applied shift.

Width rules:
- All exponent arithmetic is unsigned in EXP_W+1 bits.
- No wrap is possible because subtraction occurs only when exp > lz.

Boundaries:
- Simultaneous input accept and output drain on the same edge: both transfers occur, no bubble.
- Back-to-back stall release: ordering is preserved and no word is dropped or duplicated.
- Reset asserted mid-stream flushes both stages immediately; in-flight words are discarded.
- in_exp at maximum (all ones) with lz = 0: output unchanged, out_exp = all ones. The block performs no overflow detection.

Test Plan:
1. in_mant = 0x0000_0000_0001, in_exp = 100, tag = 3 -> 2 cycles later: out_mant = 0x8000_0000_0000, out_exp = 53, out_shift = 47, out_subn = 0, out_tag = 3.
2. in_mant = 0x0000_FFFF_0000, in_exp = 5 -> lz = 16, clamped: out_shift = 4, out_mant = 0x000F_FFF0_0000, out_exp = 0, out_subn = 1. Also in_exp = 0, in_mant = 0x0000_0000_0100 -> passthrough, out_subn = 1.
3. in_mant = 0, in_exp = 77 -> out_zero = 1, out_mant = 0, out_exp = 0, out_shift = 0. Also in_mant = 0x8000_0000_0000, in_exp = 1 -> passthrough, out_exp = 1, out_shift = 0.
4. Stream of 20 random words with out_ready = 1 -> out_valid is continuous starting 2 cycles after the first input; all results match the reference model in order.
5. Random out_ready backpressure (50%) over 200 words -> no loss or duplication, out_* stable while stalled, in_ready falls only when both stages are full and out_ready = 0.
6. Assert rst_n low with 2 words in flight -> out_valid = 0 immediately (asynchronously). After release, in_ready = 1 and no stale word is emitted.
